bool3_exerciser: RTL

- Drive side of the 3-input/1-output boolean gate interface (inputs a, b, c; output d).
- Sequences all 8 input combinations into a gate under test and samples its d output after a settle time.
- Compares each sample against a parameterised expected truth table and reports pass/fail plus a per-vector failure map.
- Sits beside a gate instance on the lab board or in a bench, started by a button/strobe.

---
 rtl/bool3_pkg.sv | 17 +
 rtl/bool3_if.sv | 10 +
 rtl/bool3_settle_timer.sv | 26 ++
 rtl/bool3_exerciser.sv | 112 +++++++++++
 4 files changed

// File: rtl/bool3_pkg.sv
// Shared types and constants for the 3-input boolean gate exerciser.
package bool3_pkg;

    typedef enum logic [1:0] {
        StIdle,
        StDrive,
        StSample,
        StDone
    } state_e;

    localparam int unsigned NUM_VEC = 8;
    localparam int unsigned VEC_W   = 3;

    // d = ~((a|b)&c), bit i indexed by {a,b,c}
    localparam logic [NUM_VEC-1:0] EXPECT_NAND_OR = 8'h57;

endpackage

// File: rtl/bool3_if.sv
// Pin-level interface to a 3-input/1-output combinational gate.
interface bool3_if;
    logic a;
    logic b;
    logic c;
    logic d_in;

    modport master (output a, output b, output c, input d_in);
    modport slave  (input a, input b, input c, output d_in);
endinterface

// File: rtl/bool3_settle_timer.sv
// Settle counter: held clear while clr is high, counts while en, flags SETTLE-1.
module bool3_settle_timer #(
    parameter int unsigned SETTLE = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic en,
    output logic tc
);

    localparam logic [3:0] TERM = 4'(SETTLE - 1);

    logic [3:0] count;

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            count <= 4'd0;
        end else if (en && !tc) begin
            count <= count + 4'd1;
        end
    end

    assign tc = (count == TERM);

endmodule

// File: rtl/bool3_exerciser.sv
// Walks all 8 input vectors through a gate and scores d against EXPECT.
// Optional macro STOP_ON_FAIL_EN ends the run at the first mismatching vector.
module bool3_exerciser
    import bool3_pkg::*;
#(
    parameter int unsigned        SETTLE = 1,
    parameter logic [NUM_VEC-1:0] EXPECT = EXPECT_NAND_OR
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
    bool3_if.master            gate,
    output logic [VEC_W-1:0]   vec_idx,
    output logic               busy,
    output logic               done,
    output logic               pass,
    output logic [3:0]         err_count,
    output logic [NUM_VEC-1:0] fail_map
);

    state_e     state;
    logic       tc;
    logic       timer_clr;
    logic       timer_en;
    logic       mismatch;
    logic       last_vec;
    logic       finish_run;
    logic [3:0] err_next;

    assign gate.a = vec_idx[2];
    assign gate.b = vec_idx[1];
    assign gate.c = vec_idx[0];

    assign timer_en  = (state == StDrive);
    assign timer_clr = !timer_en;

    bool3_settle_timer #(
        .SETTLE (SETTLE)
    ) u_timer (
        .clk (clk),
        .rst (rst),
        .clr (timer_clr),
        .en  (timer_en),
        .tc  (tc)
    );

    always_comb begin
        mismatch = (state == StSample) && (gate.d_in != EXPECT[vec_idx]);
        last_vec = (vec_idx == VEC_W'(NUM_VEC - 1));
        err_next = err_count;
        if (mismatch && (err_count < 4'(NUM_VEC))) begin
            err_next = err_count + 4'd1;
        end
`ifdef STOP_ON_FAIL_EN
        finish_run = last_vec || mismatch;
`else
        finish_run = last_vec;
`endif
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StIdle;
            vec_idx   <= '0;
            busy      <= 1'b0;
            done      <= 1'b0;
            pass      <= 1'b0;
            err_count <= 4'd0;
            fail_map  <= '0;
        end else begin
            case (state)
                StIdle: begin
                    if (start) begin
                        state     <= StDrive;
                        vec_idx   <= '0;
                        err_count <= 4'd0;
                        fail_map  <= '0;
                        pass      <= 1'b0;
                        busy      <= 1'b1;
                    end
                end
                StDrive: begin
                    if (tc) begin
                        state <= StSample;
                    end
                end
                StSample: begin
                    err_count <= err_next;
                    if (mismatch) begin
                        fail_map[vec_idx] <= 1'b1;
                    end
                    // pass uses err_next so the final sample is included
                    if (finish_run) begin
                        state <= StDone;
                        done  <= 1'b1;
                        pass  <= (err_next == 4'd0);
                    end else begin
                        state   <= StDrive;
                        vec_idx <= vec_idx + VEC_W'(1);
                    end
                end
                StDone: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

endmodule
